// File: rtl/fp32_pkg.sv
// Shared single-precision definitions: operand classes, IEEE-754 constants
// and exception flag bit positions used by the multiplier back end.
package fp32_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int          EXP_BIAS  = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_MAXF = 32'h7F7F_FFFF;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // out_flags = {invalid, overflow, underflow, special}
  localparam int FLAG_SPECIAL   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int NUM_FLAGS      = 4;

endpackage : fp32_pkg

// File: rtl/fp32_classify.sv
// Combinational operand classifier; denormals are flushed and reported as ZERO.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] word_i,
  output fp_class_e   cls_o
);

  always_comb begin
    if (word_i[30:23] == 8'h00) begin
      cls_o = CLS_ZERO;
    end else if (word_i[30:23] == EXP_MAX) begin
      cls_o = (word_i[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
    end else begin
      cls_o = CLS_NORM;
    end
  end

endmodule : fp32_classify

// File: rtl/fmul_exception_stage.sv
// Two-stage valid/ready back end for the float multiplier: stage 1 classifies
// operands and extends the exponent, stage 2 applies the IEEE fixups.
module fmul_exception_stage
  import fp32_pkg::*;
#(
  parameter bit SAT_OVERFLOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [31:0]          in_raw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [NUM_FLAGS-1:0] out_flags
);

  fp_class_e   cls_a, cls_b;
  logic [9:0]  ext_d;
  logic [1:0]  adj_d;
  logic        s1_adv, s2_adv, in_fire;

  logic        s1_valid_q;
  logic        s1_sign_q;
  fp_class_e   s1_cls_a_q, s1_cls_b_q;
  logic [9:0]  s1_ext_q;
  logic [1:0]  s1_adj_q;
  logic [22:0] s1_man_q;

  logic                 s2_valid_q;
  logic [31:0]          out_result_q, res_d;
  logic [NUM_FLAGS-1:0] out_flags_q, flags_d;
  logic signed [9:0]    exp_e;

  fp32_classify u_cls_a (.word_i(in_a), .cls_o(cls_a));
  fp32_classify u_cls_b (.word_i(in_b), .cls_o(cls_b));

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;

  // Exponent sum kept in 10 bits so the wrap the 8-bit adder suffered is visible.
  assign ext_d = {2'b00, in_a[30:23]} + {2'b00, in_b[30:23]} - 10'(EXP_BIAS);
  // Only the low two bits matter for the mod-4 carry count.
  assign adj_d = in_raw[24:23] - ext_d[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_q  <= in_a[31] ^ in_b[31];
      s1_cls_a_q <= cls_a;
      s1_cls_b_q <= cls_b;
      s1_ext_q   <= ext_d;
      s1_adj_q   <= adj_d;
      s1_man_q   <= in_raw[22:0];
    end
  end

  assign exp_e = signed'(s1_ext_q + {8'h00, s1_adj_q});

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    res_d   = {s1_sign_q, exp_e[7:0], s1_man_q};
    flags_d = '0;
    if (s1_cls_a_q == CLS_NAN || s1_cls_b_q == CLS_NAN ||
        (s1_cls_a_q == CLS_INF && s1_cls_b_q == CLS_ZERO) ||
        (s1_cls_a_q == CLS_ZERO && s1_cls_b_q == CLS_INF)) begin
      res_d                 = FP32_QNAN;
      flags_d[FLAG_INVALID] = 1'b1;
    end else if (s1_cls_a_q == CLS_INF || s1_cls_b_q == CLS_INF) begin
      res_d                 = {s1_sign_q, FP32_PINF[30:0]};
      flags_d[FLAG_SPECIAL] = 1'b1;
    end else if (s1_cls_a_q == CLS_ZERO || s1_cls_b_q == CLS_ZERO) begin
      res_d                 = {s1_sign_q, 31'h0};
      flags_d[FLAG_SPECIAL] = 1'b1;
    end else if (exp_e >= 10'sd255) begin
      res_d                  = SAT_OVERFLOW ? {s1_sign_q, FP32_MAXF[30:0]}
                                            : {s1_sign_q, FP32_PINF[30:0]};
      flags_d[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_e <= 10'sd0) begin
      res_d                   = {s1_sign_q, 31'h0};
      flags_d[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  // Output registers only reload on a real stage-1 item, so bubbles hold the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= res_d;
        out_flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule : fmul_exception_stage

// File: tb/tb_fmul_exception_stage.sv
// Directed bench for fmul_exception_stage: fixups, latency, backpressure and reset.
module tb_fmul_exception_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] in_a, in_b, in_raw;
  logic        in_ready, out_valid, in_ready_s, out_valid_s;
  logic [31:0] out_result, out_result_s;
  logic [3:0]  out_flags, out_flags_s;

  int checks   = 0;
  int failures = 0;

  fmul_exception_stage #(.SAT_OVERFLOW(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_raw(in_raw), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  fmul_exception_stage #(.SAT_OVERFLOW(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_raw(in_raw), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_result(out_result_s), .out_flags(out_flags_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One isolated transfer; result must appear exactly two cycles later.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] raw, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags, input logic [31:0] exp_sat);
    @(negedge clk);
    in_a = a; in_b = b; in_raw = raw; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "/valid_c1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "/valid_c2"}, 32'(out_valid), 32'd1);
    check({tag, "/result"}, out_result, exp_res);
    check({tag, "/flags"}, 32'(out_flags), 32'(exp_flags));
    check({tag, "/sat_result"}, out_result_s, exp_sat);
  endtask

  logic [31:0] st_a[5]   = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h40800000, 32'h3F800000};
  logic [31:0] st_b[5]   = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3F000000, 32'h3F800000};
  logic [31:0] st_raw[5] = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h40000000, 32'h3F800000};
  logic [31:0] st_exp[5] = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h40000000, 32'h3F800000};

  initial begin
    int          sent, got;
    bit          prev_stall;
    logic [31:0] held_res;
    logic [3:0]  held_flags;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_raw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_result", out_result, 32'd0);
    check("reset/out_flags", 32'(out_flags), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);

    run_one("normal",    32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 4'b0000, 32'h40C00000);
    run_one("round_cy",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 4'b0000, 32'h40100000);
    run_one("neg",       32'hC0000000, 32'h40400000, 32'hC0C00000, 32'hC0C00000, 4'b0000, 32'hC0C00000);
    run_one("overflow",  32'h7F000000, 32'h40800000, 32'h00000000, 32'h7F800000, 4'b0100, 32'h7F7FFFFF);
    run_one("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'b0010, 32'h00000000);
    run_one("inf_x_0",   32'h7F800000, 32'h80000000, 32'h00000000, 32'h7FC00000, 4'b1000, 32'h7FC00000);
    run_one("ninf",      32'hFF800000, 32'h40000000, 32'h00000000, 32'hFF800000, 4'b0001, 32'hFF800000);
    run_one("nzero",     32'h80000000, 32'h40000000, 32'h00000000, 32'h80000000, 4'b0001, 32'h80000000);
    run_one("nan",       32'h7FC00001, 32'h3F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 32'h7FC00000);

    // Backpressure: stream five items, out_ready low in cycles 3..6.
    sent = 0; got = 0; prev_stall = 1'b0; held_res = '0; held_flags = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp/held_result", out_result, held_res);
        check("bp/held_flags", 32'(out_flags), 32'(held_flags));
      end
      in_valid  = (sent < 5);
      in_a      = st_a[sent < 5 ? sent : 4];
      in_b      = st_b[sent < 5 ? sent : 4];
      in_raw    = st_raw[sent < 5 ? sent : 4];
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (c == 4) check("bp/in_ready_full", 32'(in_ready), 32'd0);
      prev_stall = out_valid && !out_ready;
      held_res   = out_result;
      held_flags = out_flags;
      if (out_valid && out_ready) begin
        check($sformatf("bp/item%0d", got), out_result, st_exp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp/count", 32'(got), 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp/no_dup", 32'(out_valid), 32'd0);

    // Fill both stages, then reset in the same cycle as an offered transfer.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = st_a[0]; in_b = st_b[0]; in_raw = st_raw[0];
    repeat (2) @(negedge clk);
    #1;
    check("rst/full_in_ready", 32'(in_ready), 32'd0);
    check("rst/full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_result", out_result, 32'd0);
    check("rst/out_flags", 32'(out_flags), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    run_one("post_rst", 32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000, 4'b0000, 32'h40800000);
    @(negedge clk);
    check("post_rst/drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fmul_exception_stage
